// File: rtl/ft232h_pkg.sv
// Shared types for the FT232H 245-style synchronous FIFO engines.
// The avail/pull handshake rule lives here so the tx and rx engines agree on it.
package ft232h_pkg;

  localparam int FT_BYTE_W = 8;

  typedef logic [FT_BYTE_W-1:0] ft_byte_t;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_WAIT,
    FL_STROBE
  } flush_state_e;

  // A byte moves on any rising edge where the producer offers it and the consumer can take it.
  function automatic logic stream_xfer(input logic avail, input logic pull);
    return avail && pull;
  endfunction

endpackage

// File: rtl/ft232h_tx_if.sv
// Byte-stream handshake and FT232H pin group for the transmit engine.
// The slave modport is the engine's view; master is the surrounding fabric/pads.
interface ft232h_tx_if;
  import ft232h_pkg::*;

  ft_byte_t in_data;
  logic     in_avail;
  logic     in_pull;
  logic     tx_enable;
  logic     tx_busy;
  logic     ft_txe_n;
  logic     ft_wr_n;
  ft_byte_t ft_data_out;
  logic     ft_data_oe;
  logic     ft_siwu_n;

  modport master (
    output in_data, in_avail, tx_enable, ft_txe_n,
    input  in_pull, tx_busy, ft_wr_n, ft_data_out, ft_data_oe, ft_siwu_n
  );

  modport slave (
    input  in_data, in_avail, tx_enable, ft_txe_n,
    output in_pull, tx_busy, ft_wr_n, ft_data_out, ft_data_oe, ft_siwu_n
  );

endinterface

// File: rtl/ft_txfifo.sv
// Small synchronous FIFO with a lookahead head: `head` is the entry that will be
// at the front after this edge's push/pop, so a registered consumer sees it with no bubble.
module ft_txfifo
  import ft232h_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  ft_byte_t      push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output ft_byte_t      head
);

  ft_byte_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    // The pushed byte is not in storage yet; forward it when it becomes the new head.
    head     = (push && (count_q == CW'(pop))) ? push_data : mem_q[rd_ptr_d];
  end

  // NOTE: nonblocking assignments in clocked logic so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/ft232h_tx.sv
// FT232H synchronous-FIFO transmit engine: buffers the byte stream, drives registered
// WR#/data/OE under TXE# backpressure, and strobes SIWU# after an idle period.
module ft232h_tx
  import ft232h_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int FLUSH_DELAY = 64
) (
  input logic        clk,
  input logic        rst,
  ft232h_tx_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (FLUSH_DELAY > 1) ? $clog2(FLUSH_DELAY) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((FLUSH_DELAY > 0) ? FLUSH_DELAY - 1 : 0);

  logic [CW-1:0] count, count_next;
  ft_byte_t      head;
  logic          pull, push, accepted;

  flush_state_e  fl_state_q, fl_state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          wr_n_q, wr_n_d;
  logic          siwu_n_q, siwu_n_d;
  logic          oe_q, oe_d;
  ft_byte_t      data_q, data_d;

  assign pull     = !rst && (count < CW'(DEPTH));
  assign push     = stream_xfer(bus.in_avail, pull);
  // The chip takes the byte only if WR# was already low and TXE# is low at this edge.
  assign accepted = !wr_n_q && !bus.ft_txe_n;

  ft_txfifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (bus.in_data),
    .pop        (accepted),
    .count      (count),
    .count_next (count_next),
    .head       (head)
  );

  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    fl_state_d = fl_state_q;
    timer_d    = timer_q;
    if (FLUSH_DELAY > 0) begin
      unique case (fl_state_q)
        FL_IDLE: begin
          if (accepted) begin
            fl_state_d = FL_WAIT;
            timer_d    = '0;
          end
        end
        FL_WAIT: begin
          if (accepted) begin
            timer_d = '0;
          end else if (timer_q == TIMER_LAST && count == '0 && wr_n_q) begin
            fl_state_d = FL_STROBE;
          end else if (timer_q != TIMER_LAST) begin
            timer_d = timer_q + 1'b1;
          end
        end
        FL_STROBE: fl_state_d = FL_IDLE;
        default:   fl_state_d = FL_IDLE;
      endcase
    end

    wr_n_d   = !((count_next != '0) && !bus.ft_txe_n && bus.tx_enable &&
                 (fl_state_d != FL_STROBE));
    siwu_n_d = (fl_state_d != FL_STROBE);
    oe_d     = bus.tx_enable;
    data_d   = head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fl_state_q <= FL_IDLE;
      timer_q    <= '0;
      wr_n_q     <= 1'b1;
      siwu_n_q   <= 1'b1;
      oe_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      fl_state_q <= fl_state_d;
      timer_q    <= timer_d;
      wr_n_q     <= wr_n_d;
      siwu_n_q   <= siwu_n_d;
      oe_q       <= oe_d;
      data_q     <= data_d;
    end
  end

  assign bus.in_pull     = pull;
  assign bus.tx_busy     = (count != '0) || !wr_n_q;
  assign bus.ft_wr_n     = wr_n_q;
  assign bus.ft_siwu_n   = siwu_n_q;
  assign bus.ft_data_oe  = oe_q;
  assign bus.ft_data_out = data_q;

endmodule
